aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Word-serial to 128-bit block assembler that sits directly upstream of `buffer`. It accepts plaintext or key words over a valid/ready handshake and packs them MSB-first into a 128-bit AES block. It presents each completed block with `block_valid` and holds it until the consumer accepts it. Glue drives `buffer.buff_in = block_out` and `buffer.buff_en = block_valid & block_ready`.

## Interface
- `WORD_W`, default 32: input word width; legal values are 8, 16, 32 and 64. N = 128/WORD_W words per block.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `in_data`  input  WORD_W  input word.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_last`  input  1  qualified by `in_valid`; marks the final word of a message and forces early block emission.
- `in_ready`  output  1  packer can accept a word this cycle; combinational.
- `block_out`  output  128  assembled block; the first word occupies bits [127:128-WORD_W].
- `block_valid`  output  1  `block_out` holds a complete block.
- `block_ready`  input  1  consumer accepts the block this cycle.
- `block_words`  output  $clog2(N)+1  number of valid words in `block_out` (1..N).
- `block_last`  output  1  the block was closed by `in_last`.

## Operation
- Two states: FILL and FULL. There is a word counter `cnt` in the range 0..N-1.
- Word accept: `in_valid & in_ready` at a rising edge.
- Block transfer: `block_valid & block_ready` at a rising edge.
- FILL:
  - `in_ready` = 1 and `block_valid` = 0.
  - On accept, write `in_data` into slot `cnt`, where slot k = bits [127-k*WORD_W -: WORD_W].
  - If `cnt == N-1` or `in_last` = 1: go to FULL. Set `block_words` = `cnt`+1 and `block_last` = `in_last`. Reset `cnt` to 0.
  - Otherwise increment `cnt`.
- FULL:
  - `block_valid` = 1. `block_out`, `block_words` and `block_last` are frozen.
  - `in_ready` = `block_ready`, which gives a pass-through for back-to-back blocks.
- Transfer without a simultaneous accept: clear `block_out` to 0, go to FILL with `cnt` = 0.
- Transfer with a simultaneous accept: clear `block_out`, then write the new word to slot 0 in the same edge.
  - If that word has `in_last` = 1, stay in FULL with `block_words` = 1 and `block_last` = 1.
  - Otherwise go to FILL with `cnt` = 1.
- Partial blocks: slots not written since the last clear read as 0, which gives zero padding. Padding uses no separate mechanism; it comes from clearing on transfer and on reset.
- `in_last` with `in_valid` = 0 is ignored.
- `in_data` is ignored when not accepted. Bubbles (`in_valid` = 0) never advance `cnt`.
- An empty block is never emitted. There is no flush without data.

## Timing
- Reset asserted (`reset` = 0), taking effect immediately with no clock edge needed:
  - State FILL, `cnt` = 0, `block_out` = 0, `block_valid` = 0, `block_words` = 0, `block_last` = 0.
  - `in_ready` is forced to 0 while reset is asserted.
  - A partial block or an unaccepted full block is discarded.
- `in_ready` = 1 from the first cycle after reset deassertion.
- Latency: `block_valid` rises in the cycle after the edge that accepts the N-th word (or the `in_last` word).
- Throughput: sustained one word per cycle with no bubble between blocks when `block_ready` = 1. A block is emitted every N cycles.
- Backpressure: while FULL and `block_ready` = 0, all outputs hold stable and `in_ready` = 0. No word is lost or overwritten.
- `block_ready` may be asserted before `block_valid`; it has no effect in FILL.

## Test plan
- **Basic fill (WORD_W = 32):** reset pulse, then words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 on consecutive cycles, with `block_ready` = 0.
  - Required: cycle after the 4th accept, `block_valid` = 1, `block_out` = 128'h0123456789ABCDEFFEDCBA9876543210, `block_words` = 4, `block_last` = 0.
- **Backpressure:** hold `block_ready` = 0 for 5 cycles after the above, with `in_valid` = 1 and `in_data` = 0x11111111.
  - Required: `in_ready` = 0 throughout and `block_out` unchanged.
  - On `block_ready` = 1: transfer and accept on the same edge, then FILL with `cnt` = 1 and slot 0 = 0x11111111.
- **Back-to-back:** continuous `in_valid` = 1 and `block_ready` = 1 with an incrementing word pattern for 12 cycles.
  - Required: `in_ready` stays 1 and `block_valid` pulses for one cycle every 4 cycles.
  - Blocks carry words 0..3, 4..7, 8..11 in MSB-first order.
- **Partial block:** words 0xAAAAAAAA, then 0xBBBBBBBB with `in_last` = 1.
  - Required: `block_out` = 128'hAAAAAAAABBBBBBBB0000000000000000, `block_words` = 2, `block_last` = 1.
  - A following full block carries no stale data.
- **Bubbles:** the 4 words of the basic-fill test interleaved with `in_valid` = 0 cycles, plus garbage on `in_data` during the bubbles.
  - Required: the same block as in the basic-fill test.
- **Async reset:** drop `reset` mid-fill (after 2 words) and again while FULL with `block_ready` = 0.
  - Required: `block_valid` and `block_out` go to 0 immediately, before the next clock edge.
  - After release, a fresh 4-word sequence produces a correct block.

Source files
------------

// File: rtl/aes_block_packer_if.sv
// Handshake bundle between a word producer, the block packer and the block consumer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface aes_block_packer_if #(
    parameter int unsigned WORD_W = 32
);
    localparam int unsigned N       = 128 / WORD_W;
    localparam int unsigned WORDS_W = $clog2(N) + 1;

    // Word input side
    logic [WORD_W-1:0]  in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;

    // Block output side
    logic [127:0]       block_out;
    logic               block_valid;
    logic               block_ready;
    logic [WORDS_W-1:0] block_words;
    logic               block_last;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output block_out,
        output block_valid,
        input  block_ready,
        output block_words,
        output block_last
    );

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  block_out,
        input  block_valid,
        output block_ready,
        input  block_words,
        input  block_last
    );
endinterface

// File: rtl/aes_block_packer.sv
// Word-serial to 128-bit block assembler. Words are packed MSB-first; a block is
// closed by the N-th word or by in_last, then held until the consumer takes it.
// Unwritten slots read as zero because the block register is cleared on every
// transfer and on reset.
module aes_block_packer #(
    parameter int unsigned WORD_W = 32
) (
    input logic               clk,
    input logic               reset,
    aes_block_packer_if.slave bus
);

    localparam int unsigned N       = 128 / WORD_W;
    localparam int unsigned CNT_W   = $clog2(N);
    localparam int unsigned WORDS_W = CNT_W + 1;

    typedef enum logic {
        StFill,
        StFull
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       block_q;
    logic [WORDS_W-1:0] words_q;
    logic               last_q;

    logic               accept;
    logic               cnt_max;
    logic [127:0]       fill_block;
    logic [127:0]       first_block;

    // In FULL, in_ready follows block_ready so a new word can enter on the transfer edge.
    // Held low during reset so nothing is accepted while state is being cleared.
    assign bus.in_ready = reset & ((state_q == StFill) | bus.block_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign cnt_max      = (cnt_q == CNT_W'(N - 1));

    assign bus.block_out   = block_q;
    assign bus.block_valid = (state_q == StFull);
    assign bus.block_words = words_q;
    assign bus.block_last  = last_q;

    // Current block with slot cnt replaced by the incoming word.
    always_comb begin
        fill_block = block_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                fill_block[127 - k * WORD_W -: WORD_W] = bus.in_data;
            end
        end
    end

    // Fresh block holding only the incoming word in slot 0; used on transfer-with-accept.
    always_comb begin
        first_block = {bus.in_data, {(128 - WORD_W){1'b0}}};
    end

    // FILL/FULL state machine with the block register and its registered descriptors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFill;
            cnt_q   <= '0;
            block_q <= '0;
            words_q <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        block_q <= fill_block;
                        if (cnt_max || bus.in_last) begin
                            state_q <= StFull;
                            words_q <= WORDS_W'(cnt_q) + WORDS_W'(1);
                            last_q  <= bus.in_last;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StFull: begin
                    if (bus.block_ready) begin
                        if (accept) begin
                            block_q <= first_block;
                            if (bus.in_last) begin
                                // Single-word message closes immediately: stay FULL.
                                words_q <= WORDS_W'(1);
                                last_q  <= 1'b1;
                            end else begin
                                state_q <= StFill;
                                cnt_q   <= CNT_W'(1);
                            end
                        end else begin
                            block_q <= '0;
                            state_q <= StFill;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StFill;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed self-checking bench for aes_block_packer with WORD_W = 32 (4 words per block).
module tb_aes_block_packer;

    localparam int unsigned WORD_W = 32;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes_block_packer_if #(.WORD_W(WORD_W)) bus ();

    aes_block_packer #(.WORD_W(WORD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] blk(input logic [31:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid word and let one rising edge pass.
    task automatic send(input logic [31:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
    endtask

    logic [31:0] basic [4];
    logic [31:0] bub_data [8];
    logic        bub_vld  [8];
    logic [127:0] exp_blk;

    initial begin
        basic[0] = 32'h01234567;
        basic[1] = 32'h89ABCDEF;
        basic[2] = 32'hFEDCBA98;
        basic[3] = 32'h76543210;

        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.block_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", bus.block_valid, 0);
        chk("rst_out", bus.block_out, 0);
        chk("rst_words", bus.block_words, 0);
        chk("rst_last", bus.block_last, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Basic fill with block_ready low
        for (int i = 0; i < 4; i++) send(basic[i], 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11111111;
        #1;
        chk("basic_valid", bus.block_valid, 1);
        chk("basic_out", bus.block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        chk("basic_words", bus.block_words, 4);
        chk("basic_last", bus.block_last, 0);
        chk("bp_in_ready0", bus.in_ready, 0);

        // Backpressure: everything holds, no word taken
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_valid", bus.block_valid, 1);
            chk("bp_out", bus.block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        end
        bus.block_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        tick();
        chk("bp_after_valid", bus.block_valid, 0);
        chk("bp_after_out", bus.block_out, blk(32'h11111111, 0, 0, 0));

        // Complete that block, then run back-to-back with block_ready held high
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            bus.in_last  = 1'b0;
            #1;
            chk("b2b_in_ready", bus.in_ready, 1);
            chk("b2b_valid", bus.block_valid, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) begin
                if (i == 0) exp_blk = blk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
                else exp_blk = blk(32'(i - 4), 32'(i - 3), 32'(i - 2), 32'(i - 1));
                chk("b2b_out", bus.block_out, exp_blk);
                chk("b2b_words", bus.block_words, 4);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_tail_valid", bus.block_valid, 1);
        chk("b2b_tail_out", bus.block_out, blk(8, 9, 10, 11));
        tick();
        chk("b2b_drain_valid", bus.block_valid, 0);
        chk("b2b_drain_out", bus.block_out, 0);
        bus.block_ready = 1'b0;

        // Partial block closed by in_last, zero padded
        send(32'hAAAAAAAA, 1'b0);
        send(32'hBBBBBBBB, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        chk("part_valid", bus.block_valid, 1);
        chk("part_out", bus.block_out, 128'hAAAAAAAABBBBBBBB0000000000000000);
        chk("part_words", bus.block_words, 2);
        chk("part_last", bus.block_last, 1);
        bus.block_ready = 1'b1;
        tick();
        bus.block_ready = 1'b0;
        chk("part_cleared", bus.block_out, 0);
        for (int i = 0; i < 4; i++) send(32'hC0DE0001 + 32'(i), 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("post_part_out", bus.block_out,
            blk(32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004));
        chk("post_part_words", bus.block_words, 4);
        chk("post_part_last", bus.block_last, 0);
        bus.block_ready = 1'b1;
        tick();
        bus.block_ready = 1'b0;

        // Bubbles with garbage data and a stray in_last while in_valid is low
        bub_vld[0] = 1'b1; bub_data[0] = basic[0];
        bub_vld[1] = 1'b0; bub_data[1] = 32'hDEADBEEF;
        bub_vld[2] = 1'b1; bub_data[2] = basic[1];
        bub_vld[3] = 1'b0; bub_data[3] = 32'hBADF00D1;
        bub_vld[4] = 1'b0; bub_data[4] = 32'hBADF00D2;
        bub_vld[5] = 1'b1; bub_data[5] = basic[2];
        bub_vld[6] = 1'b0; bub_data[6] = 32'hCAFEBABE;
        bub_vld[7] = 1'b1; bub_data[7] = basic[3];
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = bub_vld[i];
            bus.in_data  = bub_data[i];
            bus.in_last  = ~bub_vld[i];
            #1;
            chk("bub_valid_low", bus.block_valid, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        chk("bub_valid", bus.block_valid, 1);
        chk("bub_out", bus.block_out, 128'h0123456789ABCDEFFEDCBA9876543210);
        chk("bub_words", bus.block_words, 4);
        chk("bub_last", bus.block_last, 0);

        // Single last word accepted on the transfer edge stays FULL
        bus.block_ready = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_last     = 1'b1;
        bus.in_data     = 32'h55555555;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.block_ready = 1'b0;
        #1;
        chk("one_valid", bus.block_valid, 1);
        chk("one_out", bus.block_out, blk(32'h55555555, 0, 0, 0));
        chk("one_words", bus.block_words, 1);
        chk("one_last", bus.block_last, 1);
        bus.block_ready = 1'b1;
        tick();
        bus.block_ready = 1'b0;
        chk("one_drain_valid", bus.block_valid, 0);

        // Async reset mid-fill
        send(basic[0], 1'b0);
        send(basic[1], 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("mid_out", bus.block_out, blk(basic[0], basic[1], 0, 0));
        reset = 1'b0;
        #1;
        chk("mid_rst_out", bus.block_out, 0);
        chk("mid_rst_valid", bus.block_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_in_ready", bus.in_ready, 1);

        // Async reset while FULL under backpressure
        for (int i = 0; i < 4; i++) send(32'hE0000000 + 32'(i), 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("full_pre_valid", bus.block_valid, 1);
        reset = 1'b0;
        #1;
        chk("full_rst_valid", bus.block_valid, 0);
        chk("full_rst_out", bus.block_out, 0);
        chk("full_rst_words", bus.block_words, 0);
        chk("full_rst_last", bus.block_last, 0);
        tick();
        reset = 1'b1;

        // Fresh block after reset
        for (int i = 0; i < 4; i++) send(32'hD0000010 + 32'(i), 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("fresh_valid", bus.block_valid, 1);
        chk("fresh_out", bus.block_out,
            blk(32'hD0000010, 32'hD0000011, 32'hD0000012, 32'hD0000013));
        chk("fresh_words", bus.block_words, 4);
        chk("fresh_last", bus.block_last, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
